prbs_checker: RTL

PRBS_CHECKER -- requirements
Module: prbs_checker

---
 rtl/prbs_checker.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/prbs_checker.sv
// PRBS7 (x^7+x^6+1, XNOR form) serial checker.
// Seeds a local generator from the received stream, confirms it against
// LOCK_COUNT further bits, then counts bit errors while locked.
// Lock is dropped on an error burst within a 64-bit window.
module prbs_checker #(
  parameter int CNT_WIDTH   = 16,
  parameter int LOCK_COUNT  = 16,
  parameter int UNLOCK_ERRS = 4
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 EN,
  input  logic                 DIN_VALID,
  input  logic                 DIN,
  input  logic                 CLR,
  output logic                 LOCKED,
  output logic                 ERR,
  output logic [CNT_WIDTH-1:0] ERR_CNT
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int EW = $clog2(UNLOCK_ERRS + 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [EW-1:0] WERR_LAST  = EW'(UNLOCK_ERRS - 1);

  typedef enum logic [1:0] {ST_HUNT, ST_SYNC, ST_LOCKED} state_t;

  state_t         state, state_nx;
  logic [6:0]     s, s_nx;
  logic [2:0]     seed, seed_nx;
  logic [MW-1:0]  match, match_nx;
  logic [5:0]     win, win_nx;
  logic [EW-1:0]  werr, werr_nx;
  logic           err_nx, inc;
  logic [CNT_WIDTH-1:0] cnt_nx;

  // Predicted bit and mismatch against the received bit.
  logic p, miss;
  assign p    = ~(s[6] ^ s[5]);
  assign miss = DIN ^ p;

  // State register plus all counters; everything resets asynchronously.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= ST_HUNT;
      s       <= '0;
      seed    <= '0;
      match   <= '0;
      win     <= '0;
      werr    <= '0;
      LOCKED  <= 1'b0;
      ERR     <= 1'b0;
      ERR_CNT <= '0;
    end else begin
      state   <= state_nx;
      s       <= s_nx;
      seed    <= seed_nx;
      match   <= match_nx;
      win     <= win_nx;
      werr    <= werr_nx;
      LOCKED  <= (state_nx == ST_LOCKED);
      ERR     <= err_nx;
      ERR_CNT <= cnt_nx;
    end
  end

  // Next-state: hunt seeds s from DIN; sync/locked free-run s from p so a
  // received error never corrupts the generator.
  always_comb begin
    state_nx = state;
    s_nx     = s;
    seed_nx  = seed;
    match_nx = match;
    win_nx   = win;
    werr_nx  = werr;
    err_nx   = 1'b0;
    inc      = 1'b0;
    if (!EN) begin
      state_nx = ST_HUNT;
      s_nx     = '0;
      seed_nx  = '0;
      match_nx = '0;
      win_nx   = '0;
      werr_nx  = '0;
    end else if (DIN_VALID) begin
      case (state)
        ST_HUNT: begin
          s_nx    = {s[5:0], DIN};
          seed_nx = (seed == 3'd7) ? 3'd7 : seed + 3'd1;
          // all-ones is the XNOR lock-up state: keep hunting
          if (seed_nx == 3'd7 && s_nx != 7'h7F) begin
            state_nx = ST_SYNC;
            match_nx = '0;
          end
        end
        ST_SYNC: begin
          s_nx = {s[5:0], p};
          if (miss) begin
            state_nx = ST_HUNT;
            seed_nx  = '0;
            match_nx = '0;
          end else if (match == MATCH_LAST) begin
            state_nx = ST_LOCKED;
            match_nx = '0;
            win_nx   = '0;
            werr_nx  = '0;
          end else begin
            match_nx = match + 1'b1;
          end
        end
        ST_LOCKED: begin
          s_nx   = {s[5:0], p};
          win_nx = win + 6'd1;
          if (miss) begin
            err_nx = 1'b1;
            inc    = 1'b1;
            if (werr == WERR_LAST) begin
              state_nx = ST_HUNT;
              seed_nx  = '0;
              match_nx = '0;
              win_nx   = '0;
              werr_nx  = '0;
            end else begin
              // an error on the last window bit belongs to the closing window
              werr_nx = (win == 6'd63) ? '0 : werr + 1'b1;
            end
          end else if (win == 6'd63) begin
            werr_nx = '0;
          end
        end
        default: state_nx = ST_HUNT;
      endcase
    end
  end

  // Saturating error counter; clear wins over a same-cycle increment.
  always_comb begin
    cnt_nx = ERR_CNT;
    if (CLR)
      cnt_nx = '0;
    else if (inc && ERR_CNT != {CNT_WIDTH{1'b1}})
      cnt_nx = ERR_CNT + 1'b1;
  end

endmodule
